// File: rtl/lenet_fmap_streamer.sv
// lenet_fmap_streamer: captures the pooled layer-1 feature maps and replays them in lockstep to layer 2.
// Optional build macro LENET_FMAP_PINGPONG_EN selects double-buffered capture (two banks).
module lenet_fmap_streamer #(
    parameter int LANES   = 6,
    parameter int MAPSIZE = 14,
    parameter int DATA_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0]              wr_valid,
    input  logic [LANES-1:0][DATA_W-1:0]  wr_pixel,
    input  logic                          ds_ready,
    output logic                          ds_start,
    output logic [LANES-1:0]              ds_valid,
    output logic [LANES-1:0][DATA_W-1:0]  ds_pixel,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err_overflow
);
    localparam int FRAME = MAPSIZE * MAPSIZE;
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_START    = 3'd2,
        ST_STREAM   = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic [CW-1:0]                  wcnt_r [LANES];
    logic [CW-1:0]                  rcnt_r;
    logic [LANES-1:0]               lane_done_s;
    logic [LANES-1:0]               lane_done_nxt_s;
    logic [LANES-1:0]               accept_s;
    logic [LANES-1:0]               reject_s;
    logic                           all_done_nxt_s;
    logic                           clear_cnt_s;
    logic                           rd_en_s;
    logic                           ds_start_r;
    logic [LANES-1:0]               ds_valid_r;
    logic [LANES-1:0][DATA_W-1:0]   ds_pixel_r;
    logic                           frame_done_r;
    logic                           busy_r;
    logic                           err_overflow_r;

`ifdef LENET_FMAP_PINGPONG_EN
    logic                           wbank_r;
    logic                           fill_full_s;
    logic                           swap_s;
    logic [DATA_W-1:0]              mem_r [LANES][2][FRAME];
`else
    logic [DATA_W-1:0]              mem_r [LANES][FRAME];
`endif

    // Write qualification: which lane strobes are stored and which are overflow drops.
    always_comb begin
        lane_done_s     = '0;
        lane_done_nxt_s = '0;
        accept_s        = '0;
        reject_s        = '0;
`ifdef LENET_FMAP_PINGPONG_EN
        fill_full_s     = 1'b0;
`endif
        for (int c = 0; c < LANES; c++) begin
            lane_done_s[c] = (wcnt_r[c] == CNT_FULL);
        end
`ifdef LENET_FMAP_PINGPONG_EN
        fill_full_s = &lane_done_s;
        for (int c = 0; c < LANES; c++) begin
            accept_s[c] = wr_valid[c] && !lane_done_s[c];
            reject_s[c] = wr_valid[c] && fill_full_s && (state_r != ST_FILL);
        end
`else
        // The frame_done cycle still belongs to the finished frame, so writes are refused there.
        for (int c = 0; c < LANES; c++) begin
            accept_s[c] = wr_valid[c] && !lane_done_s[c] && (state_r == ST_FILL) && !frame_done_r;
            reject_s[c] = wr_valid[c] && !accept_s[c];
        end
`endif
        for (int c = 0; c < LANES; c++) begin
            lane_done_nxt_s[c] = lane_done_s[c] || (accept_s[c] && (wcnt_r[c] == CNT_LAST));
        end
        all_done_nxt_s = &lane_done_nxt_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FILL:     state_s = all_done_nxt_s ? ST_WAIT_RDY : ST_FILL;
            ST_WAIT_RDY: state_s = ds_ready ? ST_START : ST_WAIT_RDY;
            ST_START:    state_s = ST_STREAM;
            ST_STREAM:   state_s = (ds_ready && (rcnt_r == CNT_LAST)) ? ST_FLUSH : ST_STREAM;
`ifdef LENET_FMAP_PINGPONG_EN
            ST_FLUSH:    state_s = fill_full_s ? ST_WAIT_RDY : ST_FILL;
`else
            ST_FLUSH:    state_s = ST_FILL;
`endif
            default:     state_s = ST_FILL;
        endcase
    end

    // FSM outputs: read issue and counter clear strobes.
    always_comb begin
        rd_en_s = (state_r == ST_STREAM) && ds_ready;
`ifdef LENET_FMAP_PINGPONG_EN
        // A completed fill bank becomes the stream bank; the other bank takes new writes.
        swap_s      = ((state_r == ST_FILL) && all_done_nxt_s) ||
                      ((state_r == ST_FLUSH) && fill_full_s);
        clear_cnt_s = swap_s;
`else
        clear_cnt_s = (state_r == ST_FLUSH);
`endif
    end

    // Write/read counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < LANES; c++) begin
                wcnt_r[c] <= CNT_ZERO;
            end
            rcnt_r         <= CNT_ZERO;
            err_overflow_r <= 1'b0;
`ifdef LENET_FMAP_PINGPONG_EN
            wbank_r        <= 1'b0;
`endif
        end else begin
            for (int c = 0; c < LANES; c++) begin
                if (clear_cnt_s) begin
                    wcnt_r[c] <= CNT_ZERO;
                end else if (accept_s[c]) begin
                    wcnt_r[c] <= wcnt_r[c] + CNT_ONE;
                end
            end
            if (state_r == ST_START) begin
                rcnt_r <= CNT_ZERO;
            end else if (rd_en_s) begin
                rcnt_r <= rcnt_r + CNT_ONE;
            end
            if (|reject_s) begin
                err_overflow_r <= 1'b1;
            end
`ifdef LENET_FMAP_PINGPONG_EN
            if (swap_s) begin
                wbank_r <= ~wbank_r;
            end
`endif
        end
    end

    // Map buffer write port (contents are intentionally not reset).
    always_ff @(posedge clk) begin
        for (int c = 0; c < LANES; c++) begin
            if (accept_s[c]) begin
`ifdef LENET_FMAP_PINGPONG_EN
                mem_r[c][wbank_r][wcnt_r[c]] <= wr_pixel[c];
`else
                mem_r[c][wcnt_r[c]] <= wr_pixel[c];
`endif
            end
        end
    end

    // Registered downstream outputs; ds_pixel is the synchronous read register and holds on stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_start_r   <= 1'b0;
            ds_valid_r   <= '0;
            ds_pixel_r   <= '0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            ds_start_r   <= (state_s == ST_START);
            ds_valid_r   <= {LANES{rd_en_s}};
            frame_done_r <= (state_r == ST_FLUSH);
            busy_r       <= (state_s != ST_FILL);
            if (rd_en_s) begin
                for (int c = 0; c < LANES; c++) begin
`ifdef LENET_FMAP_PINGPONG_EN
                    ds_pixel_r[c] <= mem_r[c][~wbank_r][rcnt_r];
`else
                    ds_pixel_r[c] <= mem_r[c][rcnt_r];
`endif
                end
            end
        end
    end

    assign ds_start     = ds_start_r;
    assign ds_valid     = ds_valid_r;
    assign ds_pixel     = ds_pixel_r;
    assign frame_done   = frame_done_r;
    assign busy         = busy_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_lenet_fmap_streamer.sv
// Self-checking bench for lenet_fmap_streamer: scenario table, frame scoreboard, reset-abort sequence.
module tb_lenet_fmap_streamer;
    localparam int LANES   = 6;
    localparam int MAPSIZE = 14;
    localparam int DATA_W  = 8;
    localparam int FRAME   = MAPSIZE * MAPSIZE;
    localparam int NBUF    = FRAME + 16;
    localparam int NSCEN   = 8;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [LANES-1:0]              wr_valid;
    logic [LANES-1:0][DATA_W-1:0]  wr_pixel;
    logic                          ds_ready;
    logic                          ds_start;
    logic [LANES-1:0]              ds_valid;
    logic [LANES-1:0][DATA_W-1:0]  ds_pixel;
    logic                          frame_done;
    logic                          busy;
    logic                          err_overflow;

    lenet_fmap_streamer #(.LANES(LANES), .MAPSIZE(MAPSIZE), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_pixel(wr_pixel),
        .ds_ready(ds_ready), .ds_start(ds_start), .ds_valid(ds_valid), .ds_pixel(ds_pixel),
        .frame_done(frame_done), .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model state: the pixels each lane was given, and whether an illegal write happened.
    logic [DATA_W-1:0] exp_pix [LANES][FRAME];
    bit                model_err;

    // Monitor: records beats, start/done pulses, checks lockstep valid and pixel hold on stalls.
    logic [LANES-1:0][DATA_W-1:0] got_beat [NBUF];
    int  valid_cyc [NBUF];
    int  nbeat, n_start, n_done, start_cyc, done_cyc;
    bit  in_frame;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                in_frame = 1'b0;
            end
            if (ds_start) begin
                n_start++;
                start_cyc = cyc;
                in_frame  = 1'b1;
            end
            if (ds_valid != '0) begin
                check("valid_lanes_equal", 64'(ds_valid), 64'({LANES{1'b1}}));
                if (nbeat < NBUF) begin
                    got_beat[nbeat]  = ds_pixel;
                    valid_cyc[nbeat] = cyc;
                end
                nbeat++;
            end else if (in_frame && nbeat > 0 && nbeat <= NBUF) begin
                check("pixel_hold", 64'(ds_pixel), 64'(got_beat[nbeat-1]));
            end
        end
    end

    typedef struct {
        int skew5;        // cycles lane 5 starts after the others
        int stall_at;     // beat count at which ds_ready drops (-1: never)
        int stall_len;    // cycles ds_ready stays low
        bit rnd;          // random pixel data instead of the (c*16+i)%128 pattern
        bit extra2;       // a 197th write on lane 2 while still filling
        bit extra_stream; // one write while streaming
        int abort_at;     // beat count at which rst_n is asserted (-1: never)
    } scen_t;

    scen_t tbl [NSCEN];
    int    last_w;

    task automatic fill(input scen_t s);
        int idx [LANES];
        bit extra_done;
        bit all_in;
        extra_done = 1'b0;
        for (int c = 0; c < LANES; c++) idx[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            all_in = 1'b1;
            for (int c = 0; c < LANES; c++) if (idx[c] < FRAME) all_in = 1'b0;
            if (all_in && (!s.extra2 || extra_done)) break;
            wr_valid = '0;
            for (int c = 0; c < LANES; c++) begin
                if (t >= ((c == 5) ? s.skew5 : 0) && idx[c] < FRAME) begin
                    wr_valid[c] = 1'b1;
                    wr_pixel[c] = exp_pix[c][idx[c]];
                    idx[c]++;
                    last_w = cyc;
                end else if (c == 2 && s.extra2 && !extra_done && idx[2] == FRAME) begin
                    wr_valid[c] = 1'b1;
                    wr_pixel[c] = 8'h55;
                    extra_done  = 1'b1;
                    model_err   = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        wr_valid = '0;
    endtask

    task automatic run_scenario(input int id, input scen_t s);
        int  stall_left;
        bit  stalled, x_done, aborted;
        int  bad, first_bad;
        nbeat = 0; n_start = 0; n_done = 0;
        stall_left = 0; stalled = 1'b0; x_done = 1'b0; aborted = 1'b0;
        for (int c = 0; c < LANES; c++)
            for (int i = 0; i < FRAME; i++)
                exp_pix[c][i] = s.rnd ? 8'($urandom) : 8'((c * 16 + i) % 128);
        ds_ready = 1'b1;
        fill(s);
        check("no_start_during_fill", 64'(n_start), 64'd0);
        check("err_after_fill", 64'(err_overflow), 64'(model_err));
        for (int k = 0; k < 800 && n_done == 0; k++) begin
            wr_valid = '0;
            if (s.abort_at >= 0 && nbeat >= s.abort_at) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #1;
                check("abort_outputs_zero",
                      64'({ds_start, ds_valid, ds_pixel, frame_done, busy, err_overflow}), 64'd0);
                model_err = 1'b0;
                repeat (3) @(posedge clk);
                #1; rst_n = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                check("abort_no_frame_done", 64'(n_done), 64'd0);
                check("abort_idle", 64'(busy), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (!stalled && s.stall_at >= 0 && nbeat >= s.stall_at) begin
                stalled    = 1'b1;
                stall_left = s.stall_len;
            end
            ds_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (s.extra_stream && !x_done && nbeat >= 50) begin
                wr_valid[0] = 1'b1;
                wr_pixel[0] = 8'hAA;
                x_done      = 1'b1;
                model_err   = 1'b1;
            end
            @(posedge clk); #1;
        end
        wr_valid = '0;
        ds_ready = 1'b1;
        if (aborted) return;
        repeat (2) @(posedge clk);
        #1;
        check("frame_done_seen", 64'(n_done), 64'd1);
        check("start_pulses", 64'(n_start), 64'd1);
        check("beat_count", 64'(nbeat), 64'(FRAME));
        bad = 0; first_bad = -1;
        for (int b = 0; b < nbeat && b < FRAME; b++)
            for (int c = 0; c < LANES; c++)
                if (got_beat[b][c] !== exp_pix[c][b]) begin
                    bad++;
                    if (first_bad < 0) first_bad = b;
                end
        if (bad != 0) $display("scenario %0d: first bad beat %0d", id, first_bad);
        check("frame_data_errors", 64'(bad), 64'd0);
        check("start_after_last_write", 64'(start_cyc - last_w), 64'd2);
        if (nbeat > 0) begin
            check("first_valid_latency", 64'(valid_cyc[0] - start_cyc), 64'd2);
            check("valid_gap_cycles",
                  64'(valid_cyc[nbeat-1] - valid_cyc[0] + 1 - nbeat), 64'(s.stall_len));
        end
        check("frame_done_latency", 64'(done_cyc - start_cyc), 64'(198 + s.stall_len));
        check("err_end_of_frame", 64'(err_overflow), 64'(model_err));
        check("idle_after_frame", 64'(busy), 64'd0);
    endtask

    initial begin
        //         skew5 stall_at len rnd x2 xs abort
        tbl[0] = '{0,  -1,  0,  1'b0, 1'b0, 1'b0, -1};  // in-order pattern fill
        tbl[1] = '{50, -1,  0,  1'b0, 1'b0, 1'b0, -1};  // lane 5 skewed by 50
        tbl[2] = '{0,  100, 10, 1'b1, 1'b0, 1'b0, -1};  // 10-cycle stall at beat 100
        tbl[3] = '{20, -1,  0,  1'b1, 1'b1, 1'b1, -1};  // overflow writes
        tbl[4] = '{0,  -1,  0,  1'b1, 1'b0, 1'b0, 80};  // reset at beat 80
        tbl[5] = '{0,  -1,  0,  1'b0, 1'b0, 1'b0, -1};  // full frame after abort
        for (int i = 6; i < NSCEN; i++) begin
            tbl[i] = '{int'($urandom_range(0, 30)), int'($urandom_range(1, 190)),
                       int'($urandom_range(1, 8)), 1'b1, 1'b0, 1'b0, -1};
        end

        rst_n = 1'b0; wr_valid = '0; wr_pixel = '0; ds_ready = 1'b1; model_err = 1'b0;
        nbeat = 0; n_start = 0; n_done = 0; start_cyc = 0; done_cyc = 0; last_w = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({ds_start, ds_valid, ds_pixel, frame_done, busy, err_overflow}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 64'({busy, ds_start, err_overflow}), 64'd0);

        for (int i = 0; i < NSCEN; i++) run_scenario(i, tbl[i]);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
